// File: rtl/data_sramlike_bridge.sv
// M-stage data port to sram-like bus bridge: one outstanding transaction, load-data capture/bypass.
// Optional macro DATA_KSEG_MAP_EN folds kseg0/kseg1 virtual addresses onto physical.
module data_sramlike_bridge #(
  parameter logic [31:0] RDATA_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        other_stall,
  output logic [31:0] mem_rdata,
  output logic        data_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state, stateNext;
  logic [31:0] rdataR;
  logic        dataDone;
  logic [1:0]  addrLow;
  logic [31:0] addrHigh;
  logic        unusedAddrLow;

  // Sub-word placement comes from the byte enables; the address low bits are not trusted.
  always_comb begin
    data_size = 2'd2;
    addrLow   = 2'b00;
    unique case (mem_wen)
      4'b0011: begin data_size = 2'd1; addrLow = 2'b00; end
      4'b1100: begin data_size = 2'd1; addrLow = 2'b10; end
      4'b0001: begin data_size = 2'd0; addrLow = 2'b00; end
      4'b0010: begin data_size = 2'd0; addrLow = 2'b01; end
      4'b0100: begin data_size = 2'd0; addrLow = 2'b10; end
      4'b1000: begin data_size = 2'd0; addrLow = 2'b11; end
      default: begin data_size = 2'd2; addrLow = 2'b00; end
    endcase
  end

`ifdef DATA_KSEG_MAP_EN
  always_comb begin
    addrHigh = mem_addr;
    if (mem_addr[31:29] == 3'b100 || mem_addr[31:29] == 3'b101)
      addrHigh[31:29] = 3'b000;
  end
`else
  assign addrHigh = mem_addr;
`endif

  assign unusedAddrLow = ^mem_addr[1:0];
  assign data_addr     = {addrHigh[31:2], addrLow};
  assign data_wr       = |mem_wen;
  assign data_wdata    = mem_wdata;

  assign dataDone   = (state == WAIT) & data_data_ok;
  // Request is masked by reset so nothing leaks onto the bus while the interconnect is held.
  assign data_req   = (state == IDLE) & mem_en & rst;
  assign data_stall = mem_en & ~(state == HOLD) & ~dataDone;
  assign mem_rdata  = dataDone ? data_rdata : rdataR;

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (mem_en && data_addr_ok) stateNext = WAIT;
      WAIT: if (data_data_ok) stateNext = other_stall ? HOLD : IDLE;
      HOLD: if (!other_stall) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rdataR <= RDATA_RST;
    end else begin
      state <= stateNext;
      if (dataDone) rdataR <= data_rdata;
    end
  end

endmodule

// File: tb/tb_data_sramlike_bridge.sv
// Directed bench for data_sramlike_bridge: request-shaping table plus multi-cycle handshake sequences.
module tb_data_sramlike_bridge;

  localparam logic [31:0] RST_VAL = 32'h5A5A_A5A5;
`ifdef DATA_KSEG_MAP_EN
  localparam logic [31:0] K8 = 32'h0000_0000;
  localparam logic [31:0] KA = 32'h0000_0000;
  localparam logic [31:0] KB = 32'h1FC0_0000;
`else
  localparam logic [31:0] K8 = 32'h8000_0000;
  localparam logic [31:0] KA = 32'hA000_0000;
  localparam logic [31:0] KB = 32'hBFC0_0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic        other_stall;
  logic [31:0] mem_rdata;
  logic        data_stall, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int nChecks = 0;
  int nFail   = 0;

  data_sramlike_bridge #(.RDATA_RST(RST_VAL)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .other_stall(other_stall), .mem_rdata(mem_rdata),
    .data_stall(data_stall), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expWr;
    logic [1:0]  expSize;
    logic [31:0] expAddr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic aok, input logic dok, input logic [31:0] rd, input logic ost);
    mem_en = en; mem_wen = wen; mem_addr = addr; data_addr_ok = aok;
    data_data_ok = dok; data_rdata = rd; other_stall = ost;
  endtask

  initial begin
    vecs[0] = '{4'b0000, 32'h1234_5673, 32'h1111_1111, 1'b0, 2'd2, 32'h1234_5670};
    vecs[1] = '{4'b1111, 32'h0000_0043, 32'h2222_2222, 1'b1, 2'd2, 32'h0000_0040};
    vecs[2] = '{4'b0011, 32'h4000_0011, 32'h0000_3333, 1'b1, 2'd1, 32'h4000_0010};
    vecs[3] = '{4'b1100, 32'h8000_0013, 32'h4444_0000, 1'b1, 2'd1, K8 | 32'h12};
    vecs[4] = '{4'b0001, 32'hC000_0003, 32'h0000_0055, 1'b1, 2'd0, 32'hC000_0000};
    vecs[5] = '{4'b0010, 32'h0000_0100, 32'h0000_6600, 1'b1, 2'd0, 32'h0000_0101};
    vecs[6] = '{4'b0100, 32'h8000_0013, 32'h0077_0000, 1'b1, 2'd0, K8 | 32'h12};
    vecs[7] = '{4'b1000, 32'h0000_0200, 32'h8800_0000, 1'b1, 2'd0, 32'h0000_0203};
    vecs[8] = '{4'b0110, 32'h0000_0307, 32'h0099_9900, 1'b1, 2'd2, 32'h0000_0304};
    vecs[9] = '{4'b0101, 32'hA000_0001, 32'h00AA_00AA, 1'b1, 2'd2, KA};

    // Reset with a pending load: no request, stall follows mem_en, rdata at reset value
    rst = 1'b0; mem_wdata = '0;
    drive(1'b1, 4'b0000, 32'h0000_1000, 1'b1, 1'b0, '0, 1'b0);
    mid();
    chk("rst_req", data_req, 1'b0);
    chk("rst_stall", data_stall, 1'b1);
    chk("rst_rdata", mem_rdata, RST_VAL);
    adv();
    rst = 1'b1;
    drive(1'b0, 4'b0000, '0, 1'b0, 1'b0, '0, 1'b0);
    adv();

    // Request shaping: addr_ok held low so FSM stays IDLE for every vector
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].wen, vecs[i].addr, 1'b0, 1'b0, '0, 1'b0);
      mem_wdata = vecs[i].wdata;
      mid();
      chk($sformatf("v%0d_req", i), data_req, 1'b1);
      chk($sformatf("v%0d_wr", i), data_wr, vecs[i].expWr);
      chk($sformatf("v%0d_size", i), data_size, vecs[i].expSize);
      chk($sformatf("v%0d_addr", i), data_addr, vecs[i].expAddr);
      chk($sformatf("v%0d_wdata", i), data_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_stall", i), data_stall, 1'b1);
      adv();
    end

    // Load with data_ok two cycles after address acceptance
    drive(1'b1, 4'b0000, 32'hBFC0_0104, 1'b1, 1'b0, '0, 1'b0);
    mid();
    chk("ld_c0_req", data_req, 1'b1);
    chk("ld_c0_stall", data_stall, 1'b1);
    chk("ld_c0_addr", data_addr, KB | 32'h104);
    adv();
    drive(1'b1, 4'b0000, 32'hBFC0_0104, 1'b0, 1'b0, '0, 1'b0);
    mid();
    chk("ld_c1_req", data_req, 1'b0);
    chk("ld_c1_stall", data_stall, 1'b1);
    adv();
    drive(1'b1, 4'b0000, 32'hBFC0_0104, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    mid();
    chk("ld_c2_req", data_req, 1'b0);
    chk("ld_c2_stall", data_stall, 1'b0);
    chk("ld_c2_rdata", mem_rdata, 32'h1234_5678);
    adv();
    drive(1'b0, 4'b0000, '0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    mid();
    chk("ld_c3_hold_rdata", mem_rdata, 32'h1234_5678);
    chk("ld_c3_req", data_req, 1'b0);
    adv();

    // Best-case latency with other_stall, then HOLD for three more cycles
    drive(1'b1, 4'b0000, 32'h0000_2000, 1'b1, 1'b0, '0, 1'b0);
    adv();
    drive(1'b1, 4'b0000, 32'h0000_2000, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
    mid();
    chk("hs_c1_stall", data_stall, 1'b0);
    chk("hs_c1_rdata", mem_rdata, 32'hCAFE_F00D);
    adv();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'b0000, 32'h0000_2000, 1'b1, (c == 1), 32'hDEAD_BEEF, 1'b1);
      mid();
      chk($sformatf("hold%0d_req", c), data_req, 1'b0);
      chk($sformatf("hold%0d_stall", c), data_stall, 1'b0);
      chk($sformatf("hold%0d_rdata", c), mem_rdata, 32'hCAFE_F00D);
      adv();
    end
    drive(1'b1, 4'b0000, 32'h0000_2000, 1'b0, 1'b0, '0, 1'b0);
    mid();
    chk("hold_fall_req", data_req, 1'b0);
    chk("hold_fall_stall", data_stall, 1'b0);
    adv();
    mid();
    chk("hold_idle_req", data_req, 1'b1);
    chk("hold_idle_stall", data_stall, 1'b1);
    adv();

    // addr_ok withheld; mem_en withdrawn in cycle 3; stray addr_ok with no request
    for (int c = 0; c < 6; c++) begin
      drive(c < 3 || c == 5, 4'b1111, 32'h0000_1000, (c == 4), 1'b0, '0, 1'b0);
      mem_wdata = 32'h0F0F_0F0F;
      mid();
      chk($sformatf("wait%0d_req", c), data_req, (c < 3 || c == 5));
      chk($sformatf("wait%0d_addr", c), data_addr, 32'h0000_1000);
      adv();
    end

    // mem_en dropped while WAIT: transaction still completes and is captured
    drive(1'b1, 4'b0000, 32'h0000_3000, 1'b1, 1'b0, '0, 1'b0);
    adv();
    drive(1'b0, 4'b0000, 32'h0000_3000, 1'b0, 1'b0, '0, 1'b0);
    mid();
    chk("cx_c1_stall", data_stall, 1'b0);
    chk("cx_c1_req", data_req, 1'b0);
    adv();
    drive(1'b0, 4'b0000, 32'h0000_3000, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0);
    mid();
    chk("cx_c2_rdata", mem_rdata, 32'h0BAD_F00D);
    adv();
    drive(1'b1, 4'b0000, 32'h0000_3004, 1'b0, 1'b0, '0, 1'b0);
    mid();
    chk("cx_c3_rdata", mem_rdata, 32'h0BAD_F00D);
    chk("cx_c3_req", data_req, 1'b1);
    adv();

    // Reset in WAIT, then a late data_ok pulse must be ignored
    drive(1'b1, 4'b0000, 32'h0000_4000, 1'b1, 1'b0, '0, 1'b0);
    adv();
    drive(1'b1, 4'b0000, 32'h0000_4000, 1'b0, 1'b0, '0, 1'b0);
    mid();
    chk("rw_wait_stall", data_stall, 1'b1);
    rst = 1'b0;
    #1;
    chk("rw_rst_req", data_req, 1'b0);
    chk("rw_rst_stall", data_stall, 1'b1);
    chk("rw_rst_rdata", mem_rdata, RST_VAL);
    adv();
    rst = 1'b1;
    drive(1'b0, 4'b0000, 32'h0000_4000, 1'b0, 1'b1, 32'h5555_1234, 1'b0);
    mid();
    chk("rw_pulse_rdata", mem_rdata, RST_VAL);
    adv();
    drive(1'b1, 4'b0000, 32'h0000_4000, 1'b0, 1'b0, '0, 1'b0);
    mid();
    chk("rw_after_rdata", mem_rdata, RST_VAL);
    chk("rw_after_req", data_req, 1'b1);
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
